// File: rtl/guess_round_controller.sv
// Round sequencer for a Bulls-and-Cows game: digit entry, validation, scoring window, result latch, win/lose.
// Optional DUP_CHECK_EN macro enables duplicate-digit rejection in the VALIDATE state.
module guess_round_controller #(
   parameter int MAX_ATTEMPTS  = 10,
   parameter int ATT_W         = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_digit_valid,
   input  logic [3:0]        i_digit,
   input  logic              i_clear,
   input  logic              i_new_game,
   input  logic [3:0]        i_strike,
   input  logic [3:0]        i_ball,
   output logic [15:0]       o_guess,
   output logic [2:0]        o_entry_count,
   output logic              o_check_en,
   output logic              o_result_valid,
   output logic [3:0]        o_result_strike,
   output logic [3:0]        o_result_ball,
   output logic [ATT_W-1:0]  o_attempts,
   output logic              o_dup_err,
   output logic              o_win,
   output logic              o_lose
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [ATT_W-1:0] ATT_MAX     = ATT_W'(MAX_ATTEMPTS);

   typedef enum logic [2:0] {
      S_ENTRY,
      S_VALIDATE,
      S_CHECK,
      S_REPORT,
      S_WIN,
      S_LOSE
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [15:0]        r_guess;
   logic [2:0]         r_entry_count;
   logic [SET_W-1:0]   r_settle_cnt;
   logic [3:0]         r_result_strike;
   logic [3:0]         r_result_ball;
   logic [ATT_W-1:0]   r_attempts;
   logic               r_dup_err;
   logic               w_digit_ok;
   logic               w_settle_done;
   logic               w_dup;

   assign w_digit_ok    = i_digit_valid && (i_digit <= 4'd9);
   assign w_settle_done = (r_state == S_CHECK) && (r_settle_cnt == SETTLE_LAST);

`ifdef DUP_CHECK_EN
   assign w_dup = (r_guess[15:12] == r_guess[11:8]) ||
                  (r_guess[15:12] == r_guess[7:4])  ||
                  (r_guess[15:12] == r_guess[3:0])  ||
                  (r_guess[11:8]  == r_guess[7:4])  ||
                  (r_guess[11:8]  == r_guess[3:0])  ||
                  (r_guess[7:4]   == r_guess[3:0]);
`else
   assign w_dup = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_ENTRY;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      o_check_en     = 1'b0;
      o_result_valid = 1'b0;
      o_win          = 1'b0;
      o_lose         = 1'b0;
      case (r_state)
         S_CHECK:  o_check_en     = 1'b1;
         S_REPORT: o_result_valid = 1'b1;
         S_WIN:    o_win          = 1'b1;
         S_LOSE:   o_lose         = 1'b1;
         default:  ;
      endcase
      if (i_new_game) begin
         w_next_state = S_ENTRY;
      end else begin
         case (r_state)
            S_ENTRY: begin
               if (!i_clear && w_digit_ok && (r_entry_count == 3'd3)) begin
                  w_next_state = S_VALIDATE;
               end
            end
            S_VALIDATE: w_next_state = w_dup ? S_ENTRY : S_CHECK;
            S_CHECK: begin
               if (w_settle_done) begin
                  w_next_state = S_REPORT;
               end
            end
            // A strike of exactly 4 wins even on the final attempt.
            S_REPORT: begin
               if (r_result_strike == 4'd4) begin
                  w_next_state = S_WIN;
               end else if (r_attempts >= ATT_MAX) begin
                  w_next_state = S_LOSE;
               end else begin
                  w_next_state = S_ENTRY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_guess         <= 16'hFFFF;
         r_entry_count   <= 3'd0;
         r_settle_cnt    <= '0;
         r_result_strike <= 4'd0;
         r_result_ball   <= 4'd0;
         r_attempts      <= '0;
         r_dup_err       <= 1'b0;
      end else if (i_new_game) begin
         r_guess         <= 16'hFFFF;
         r_entry_count   <= 3'd0;
         r_settle_cnt    <= '0;
         r_result_strike <= 4'd0;
         r_result_ball   <= 4'd0;
         r_attempts      <= '0;
         r_dup_err       <= 1'b0;
      end else begin
         r_dup_err    <= 1'b0;
         r_settle_cnt <= '0;
         case (r_state)
            S_ENTRY: begin
               if (i_clear) begin
                  r_guess       <= 16'hFFFF;
                  r_entry_count <= 3'd0;
               end else if (w_digit_ok) begin
                  case (r_entry_count[1:0])
                     2'd0:    r_guess[15:12] <= i_digit;
                     2'd1:    r_guess[11:8]  <= i_digit;
                     2'd2:    r_guess[7:4]   <= i_digit;
                     default: r_guess[3:0]   <= i_digit;
                  endcase
                  r_entry_count <= r_entry_count + 3'd1;
               end
            end
            S_VALIDATE: begin
               if (w_dup) begin
                  r_guess       <= 16'hFFFF;
                  r_entry_count <= 3'd0;
                  r_dup_err     <= 1'b1;
               end
            end
            S_CHECK: begin
               if (w_settle_done) begin
                  r_result_strike <= i_strike;
                  r_result_ball   <= i_ball;
                  if (r_attempts < ATT_MAX) begin
                     r_attempts <= r_attempts + 1'b1;
                  end
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            S_REPORT: begin
               if (w_next_state == S_ENTRY) begin
                  r_guess       <= 16'hFFFF;
                  r_entry_count <= 3'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_guess         = r_guess;
   assign o_entry_count   = r_entry_count;
   assign o_result_strike = r_result_strike;
   assign o_result_ball   = r_result_ball;
   assign o_attempts      = r_attempts;
   assign o_dup_err       = r_dup_err;

endmodule

// File: tb/tb_guess_round_controller.sv
// Self-checking bench for guess_round_controller: entry vector table plus scoreboarded guess rounds.
module tb_guess_round_controller;

   localparam int MAX_ATT = 3;
   localparam int ATT_W   = 4;
   localparam int SETTLE  = 2;
   localparam logic [15:0] SECRET = 16'h1234;

   logic              i_clk;
   logic              i_rst;
   logic              i_digit_valid;
   logic [3:0]        i_digit;
   logic              i_clear;
   logic              i_new_game;
   logic [3:0]        i_strike;
   logic [3:0]        i_ball;
   logic [15:0]       o_guess;
   logic [2:0]        o_entry_count;
   logic              o_check_en;
   logic              o_result_valid;
   logic [3:0]        o_result_strike;
   logic [3:0]        o_result_ball;
   logic [ATT_W-1:0]  o_attempts;
   logic              o_dup_err;
   logic              o_win;
   logic              o_lose;

   guess_round_controller #(
      .MAX_ATTEMPTS (MAX_ATT),
      .ATT_W        (ATT_W),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_digit_valid  (i_digit_valid),
      .i_digit        (i_digit),
      .i_clear        (i_clear),
      .i_new_game     (i_new_game),
      .i_strike       (i_strike),
      .i_ball         (i_ball),
      .o_guess        (o_guess),
      .o_entry_count  (o_entry_count),
      .o_check_en     (o_check_en),
      .o_result_valid (o_result_valid),
      .o_result_strike(o_result_strike),
      .o_result_ball  (o_result_ball),
      .o_attempts     (o_attempts),
      .o_dup_err      (o_dup_err),
      .o_win          (o_win),
      .o_lose         (o_lose)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Scoring logic stand-in: strike/ball of the presented guess against a fixed secret.
   function automatic logic [7:0] scoreOf(input logic [15:0] g);
      logic [15:0] sec;
      logic [3:0]  s;
      logic [3:0]  b;
      sec = SECRET;
      s = 4'd0;
      b = 4'd0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (g[15-4*i -: 4] == sec[15-4*j -: 4]) begin
               if (i == j) s = s + 4'd1;
               else        b = b + 4'd1;
            end
         end
      end
      return {s, b};
   endfunction

   assign {i_strike, i_ball} = scoreOf(o_guess);

   typedef struct {
      logic [3:0]       s;
      logic [3:0]       b;
      logic [ATT_W-1:0] a;
   } expRes_t;

   typedef struct {
      logic        dv;
      logic [3:0]  d;
      logic        clr;
      logic        ng;
      logic [15:0] eGuess;
      logic [2:0]  eCount;
   } vec_t;

   expRes_t          expQ[$];
   expRes_t          monE;
   vec_t             vecs[8];
   logic [ATT_W-1:0] expAttempts;
   int               nCompared;
   int               nMismatched;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idleInputs();
      i_digit_valid = 1'b0;
      i_digit       = 4'd0;
      i_clear       = 1'b0;
      i_new_game    = 1'b0;
   endtask

   task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic clr, input logic ng);
      i_digit_valid = dv;
      i_digit       = d;
      i_clear       = clr;
      i_new_game    = ng;
      step();
      idleInputs();
   endtask

   // Enters four digits; returns one cycle after the 4th digit was sampled.
   task automatic submitGuess(input logic [15:0] g, input bit expectScore);
      expRes_t e;
      for (int i = 0; i < 4; i++) begin
         if (i == 3 && expectScore) begin
            expAttempts = expAttempts + 1'b1;
            {e.s, e.b} = scoreOf(g);
            e.a = expAttempts;
            expQ.push_back(e);
         end
         applyStimulus(1'b1, g[15-4*i -: 4], 1'b0, 1'b0);
      end
   endtask

   // Walks cycles 1..2+SETTLE after the 4th digit, ending in cycle 3+SETTLE.
   task automatic runLatency(input string tag);
      for (int c = 1; c <= 2 + SETTLE; c++) begin
         checkOutput($sformatf("%s check_en c%0d", tag, c), 32'(o_check_en),
                     32'((c >= 2) && (c <= 1 + SETTLE)));
         checkOutput($sformatf("%s result_valid c%0d", tag, c), 32'(o_result_valid),
                     32'(c == 2 + SETTLE));
         step();
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_rst && o_result_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected result_valid", 32'(o_result_valid), 32'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("sb result_strike", 32'(o_result_strike), 32'(monE.s));
            checkOutput("sb result_ball", 32'(o_result_ball), 32'(monE.b));
            checkOutput("sb attempts", 32'(o_attempts), 32'(monE.a));
         end
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, " guess"}, 32'(o_guess), 32'h0000FFFF);
      checkOutput({tag, " entry_count"}, 32'(o_entry_count), 32'd0);
      checkOutput({tag, " check_en"}, 32'(o_check_en), 32'd0);
      checkOutput({tag, " result_valid"}, 32'(o_result_valid), 32'd0);
      checkOutput({tag, " result_strike"}, 32'(o_result_strike), 32'd0);
      checkOutput({tag, " result_ball"}, 32'(o_result_ball), 32'd0);
      checkOutput({tag, " attempts"}, 32'(o_attempts), 32'd0);
      checkOutput({tag, " dup_err"}, 32'(o_dup_err), 32'd0);
      checkOutput({tag, " win"}, 32'(o_win), 32'd0);
      checkOutput({tag, " lose"}, 32'(o_lose), 32'd0);
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      expAttempts = '0;
      idleInputs();
      i_rst = 1'b1;

      vecs[0] = '{1'b1, 4'd1,  1'b0, 1'b0, 16'h1FFF, 3'd1};
      vecs[1] = '{1'b1, 4'hA,  1'b0, 1'b0, 16'h1FFF, 3'd1};
      vecs[2] = '{1'b1, 4'd2,  1'b0, 1'b0, 16'h12FF, 3'd2};
      vecs[3] = '{1'b0, 4'd5,  1'b0, 1'b0, 16'h12FF, 3'd2};
      vecs[4] = '{1'b1, 4'd3,  1'b1, 1'b0, 16'hFFFF, 3'd0};
      vecs[5] = '{1'b1, 4'd9,  1'b0, 1'b0, 16'h9FFF, 3'd1};
      vecs[6] = '{1'b1, 4'd5,  1'b0, 1'b1, 16'hFFFF, 3'd0};
      vecs[7] = '{1'b1, 4'd0,  1'b0, 1'b0, 16'h0FFF, 3'd1};

      step();
      step();
      checkResetState("reset");
      i_rst = 1'b0;

      // Entry table: digit accept/ignore, clear priority, new_game priority.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(vecs[k].dv, vecs[k].d, vecs[k].clr, vecs[k].ng);
         checkOutput($sformatf("vec%0d guess", k), 32'(o_guess), 32'(vecs[k].eGuess));
         checkOutput($sformatf("vec%0d entry_count", k), 32'(o_entry_count), 32'(vecs[k].eCount));
         checkOutput($sformatf("vec%0d check_en", k), 32'(o_check_en), 32'd0);
      end
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("clear guess", 32'(o_guess), 32'h0000FFFF);

      // Miss round with full latency walk.
      submitGuess(16'h5678, 1'b1);
      runLatency("miss");
      checkOutput("miss entry_count", 32'(o_entry_count), 32'd0);
      checkOutput("miss guess", 32'(o_guess), 32'h0000FFFF);
      checkOutput("miss win", 32'(o_win), 32'd0);
      checkOutput("miss lose", 32'(o_lose), 32'd0);

      // Duplicate-digit guess.
`ifdef DUP_CHECK_EN
      submitGuess(16'h1123, 1'b0);
      checkOutput("dup c1 dup_err", 32'(o_dup_err), 32'd0);
      step();
      checkOutput("dup c2 dup_err", 32'(o_dup_err), 32'd1);
      checkOutput("dup c2 guess", 32'(o_guess), 32'h0000FFFF);
      checkOutput("dup c2 entry_count", 32'(o_entry_count), 32'd0);
      checkOutput("dup c2 check_en", 32'(o_check_en), 32'd0);
      step();
      checkOutput("dup c3 dup_err", 32'(o_dup_err), 32'd0);
      checkOutput("dup attempts", 32'(o_attempts), 32'(expAttempts));
`else
      submitGuess(16'h1123, 1'b1);
      runLatency("dup");
      checkOutput("dup dup_err", 32'(o_dup_err), 32'd0);
      checkOutput("dup attempts", 32'(o_attempts), 32'(expAttempts));
`endif

      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      expAttempts = '0;
      checkOutput("ng attempts", 32'(o_attempts), 32'd0);

      // Winning round, then sticky win ignoring digits and clear.
      submitGuess(16'h1234, 1'b1);
      runLatency("win");
      checkOutput("win win", 32'(o_win), 32'd1);
      checkOutput("win lose", 32'(o_lose), 32'd0);
      checkOutput("win result_strike", 32'(o_result_strike), 32'd4);
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
      checkOutput("win hold guess", 32'(o_guess), 32'h00001234);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("win clear guess", 32'(o_guess), 32'h00001234);
      checkOutput("win still", 32'(o_win), 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      expAttempts = '0;
      checkResetState("ng after win");

      // Exhaust attempts.
      for (int r = 0; r < MAX_ATT; r++) begin
         submitGuess(16'h5678, 1'b1);
         runLatency($sformatf("lose r%0d", r));
         checkOutput($sformatf("lose r%0d lose", r), 32'(o_lose), 32'(r == MAX_ATT - 1));
      end
      checkOutput("lose attempts", 32'(o_attempts), 32'(MAX_ATT));
      checkOutput("lose win", 32'(o_win), 32'd0);
      step();
      checkOutput("lose held", 32'(o_lose), 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      expAttempts = '0;
      checkOutput("ng lose", 32'(o_lose), 32'd0);
      checkOutput("ng lose attempts", 32'(o_attempts), 32'd0);

      // Win on the final attempt beats lose.
      for (int r = 0; r < MAX_ATT - 1; r++) begin
         submitGuess(16'h5678, 1'b1);
         runLatency($sformatf("last r%0d", r));
      end
      submitGuess(16'h1234, 1'b1);
      runLatency("last win");
      checkOutput("last win win", 32'(o_win), 32'd1);
      checkOutput("last win lose", 32'(o_lose), 32'd0);
      checkOutput("last win attempts", 32'(o_attempts), 32'(MAX_ATT));
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      expAttempts = '0;

      // new_game during the first CHECK cycle aborts the round.
      submitGuess(16'h1243, 1'b1);
      runLatency("pre abort");
      checkOutput("pre abort attempts", 32'(o_attempts), 32'd1);
      submitGuess(16'h5678, 1'b0);
      step();
      checkOutput("abort check_en", 32'(o_check_en), 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      expAttempts = '0;
      for (int c = 0; c < SETTLE + 2; c++) begin
         checkOutput($sformatf("abort c%0d result_valid", c), 32'(o_result_valid), 32'd0);
         checkOutput($sformatf("abort c%0d check_en", c), 32'(o_check_en), 32'd0);
         step();
      end
      checkResetState("abort");

      // Synchronous reset mid-entry.
      submitGuess(16'h1243, 1'b1);
      runLatency("pre rst");
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
      checkOutput("pre rst entry_count", 32'(o_entry_count), 32'd2);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      checkResetState("mid rst");

      step();
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
